// File: rtl/prbs_checker_pkg.sv
// Shared PRBS definitions used by the checker and the generator stage:
// default order, feedback tap offset, state encoding and counter width.
package prbs_checker_pkg;

   localparam int DEF_ORDER  = 9;
   localparam int TAP_OFFSET = 4;
   localparam int DEF_CNT_W  = 32;

   typedef enum logic {
      SYNC = 1'b0,
      LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/prbs_ref_lfsr.sv
// Local reference LFSR for the PRBS checker: keeps the last ORDER bits and
// predicts the next one. Seeded from the line in SYNC, free-running in LOCK.
module prbs_ref_lfsr
   import prbs_checker_pkg::*;
#(
   parameter int ORDER = DEF_ORDER
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic             shift_en,
   input  logic             use_pred,
   input  logic             rx_bit,
   output logic [ORDER-1:0] hist,
   output logic             pred
);

   logic in_bit;

   assign pred   = hist[TAP_OFFSET-1] ^ hist[ORDER-1];
   assign in_bit = use_pred ? pred : rx_bit;

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         hist <= '0;
      end else if (shift_en) begin
         hist <= {hist[ORDER-2:0], in_bit};
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS BER checker: self-synchronises a reference LFSR from the
// incoming stream, then counts compared bits and errors while locked.
module prbs_checker
   import prbs_checker_pkg::*;
#(
   parameter int ORDER    = DEF_ORDER,
   parameter int SYNC_LEN = 32,
   parameter int WIN_LEN  = 64,
   parameter int ERR_THR  = 8,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_valid,
   input  logic             i_rx_bit,
   input  logic             i_clear,
   output logic             o_lock,
   output logic             o_lock_lost,
   output logic             o_err_pulse,
   output logic [CNT_W-1:0] o_bit_count,
   output logic [CNT_W-1:0] o_err_count
);

   localparam int FILL_W  = $clog2(ORDER + 1);
   localparam int MATCH_W = $clog2(SYNC_LEN + 1);
   localparam int WIN_W   = $clog2(WIN_LEN + 1);

   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(ORDER);
   localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(SYNC_LEN);
   localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WIN_LEN - 1);
   localparam logic [WIN_W-1:0]   ERR_LIMIT = WIN_W'(ERR_THR);

   state_t             state, state_nxt;
   logic [FILL_W-1:0]  fill, fill_nxt;
   logic [MATCH_W-1:0] match, match_nxt;
   logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
   logic [WIN_W-1:0]   win_err, win_err_nxt, win_err_sum;
   logic [CNT_W-1:0]   bit_nxt, err_nxt;
   logic               lost_nxt, epulse_nxt;
   logic               sample, mismatch, pred;
   logic [ORDER-1:0]   hist;

   assign sample   = i_enable && i_valid;
   assign mismatch = (i_rx_bit != pred);
   assign o_lock   = (state == LOCK);

   prbs_ref_lfsr #(.ORDER(ORDER)) u_ref (
      .clock    (clock),
      .i_reset  (i_reset),
      .shift_en (sample),
      .use_pred (state == LOCK),
      .rx_bit   (i_rx_bit),
      .hist     (hist),
      .pred     (pred)
   );

   // An all-zero history predicts zeros forever, so it is never allowed to build a match run.
   always_comb begin
      state_nxt   = state;
      fill_nxt    = fill;
      match_nxt   = match;
      win_cnt_nxt = win_cnt;
      win_err_nxt = win_err;
      win_err_sum = win_err + WIN_W'(mismatch);
      bit_nxt     = o_bit_count;
      err_nxt     = o_err_count;
      lost_nxt    = 1'b0;
      epulse_nxt  = 1'b0;
      if (sample) begin
         case (state)
            SYNC: begin
               if (fill != FILL_FULL) begin
                  fill_nxt = fill + 1'b1;
               end else if ((hist == '0) || mismatch) begin
                  match_nxt = '0;
               end else if (match + 1'b1 == MATCH_TGT) begin
                  match_nxt = '0;
                  state_nxt = LOCK;
               end else begin
                  match_nxt = match + 1'b1;
               end
            end
            LOCK: begin
               epulse_nxt = mismatch;
               if (o_bit_count != '1) bit_nxt = o_bit_count + 1'b1;
               if (mismatch && (o_err_count != '1)) err_nxt = o_err_count + 1'b1;
               if (win_cnt == WIN_LAST) begin
                  win_cnt_nxt = '0;
                  win_err_nxt = '0;
                  if (win_err_sum > ERR_LIMIT) begin
                     state_nxt = SYNC;
                     fill_nxt  = '0;
                     match_nxt = '0;
                     lost_nxt  = 1'b1;
                  end
               end else begin
                  win_cnt_nxt = win_cnt + 1'b1;
                  win_err_nxt = win_err_sum;
               end
            end
            default: state_nxt = SYNC;
         endcase
      end
      if (i_enable && i_clear) begin
         bit_nxt = '0;
         err_nxt = '0;
      end
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state       <= SYNC;
         fill        <= '0;
         match       <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         o_bit_count <= '0;
         o_err_count <= '0;
         o_lock_lost <= 1'b0;
         o_err_pulse <= 1'b0;
      end else begin
         state       <= state_nxt;
         fill        <= fill_nxt;
         match       <= match_nxt;
         win_cnt     <= win_cnt_nxt;
         win_err     <= win_err_nxt;
         o_bit_count <= bit_nxt;
         o_err_count <= err_nxt;
         o_lock_lost <= lost_nxt;
         o_err_pulse <= epulse_nxt;
      end
   end

endmodule
